button_pulse_conditioner: RTL and testbench

Conditions the four raw navigation push-buttons of the board into clean single-cycle enable pulses for the RTC control top-level (`enUP`, `enDOWN`, `enRIGHT`, `enLEFT`), which feed the configuration counters that edit time, date and timer fields. Each button is synchronized, debounced on press and release, and auto-repeats while held. Simultaneous pulses are arbitrated so the counters never see more than one edit command per cycle.

---
 rtl/button_pulse_conditioner_pkg.sv | 28 ++
 rtl/button_pulse_conditioner_channel.sv | 110 +++++++++++
 rtl/button_pulse_conditioner.sv | 64 ++++++
 tb/tb_button_pulse_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and constants for the navigation button conditioner.
// Holds the per-channel FSM state enum, channel indices and the fixed-priority grant helper.
package button_pulse_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD_DELAY,
    HELD_REPEAT,
    RELEASE_WAIT
  } btn_state_e;

  localparam int CH_UP    = 3;
  localparam int CH_DOWN  = 2;
  localparam int CH_RIGHT = 1;
  localparam int CH_LEFT  = 0;
  localparam int NUM_CH   = 4;

  // One-hot grant of the highest-priority request (up > down > right > left).
  function automatic logic [NUM_CH-1:0] priority_grant(input logic [NUM_CH-1:0] req);
    priority_grant = '0;
    if (req[CH_UP])         priority_grant[CH_UP]    = 1'b1;
    else if (req[CH_DOWN])  priority_grant[CH_DOWN]  = 1'b1;
    else if (req[CH_RIGHT]) priority_grant[CH_RIGHT] = 1'b1;
    else if (req[CH_LEFT])  priority_grant[CH_LEFT]  = 1'b1;
  endfunction

endpackage

// File: rtl/button_pulse_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM and its counter.
// `fire` is a combinational request for the top-level arbiter; `held` is registered.
module button_channel
  import button_pulse_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 20_000_000,
  parameter bit REPEAT_EN           = 1'b1,
  parameter int CNT_W               = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic fire,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    held_d  = held_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
          fire    = 1'b1;
          held_d  = 1'b1;
        end
      end
      HELD_DELAY: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_LAST) begin
          // Without auto-repeat the counter parks at its terminal value instead of wrapping.
          if (REPEAT_EN) begin
            state_d = HELD_REPEAT;
            cnt_d   = '0;
            fire    = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      HELD_REPEAT: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          cnt_d = '0;
          fire  = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A short low glitch returns to the hold phase silently and restarts the repeat delay.
        if (sync2_q) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  assign held = held_q;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Four conditioned navigation buttons feeding a fixed-priority arbiter.
// The registered grant guarantees at most one edit pulse per cycle.
module button_pulse_conditioner
  import button_pulse_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 20_000_000,
  parameter bit REPEAT_EN           = 1'b1,
  parameter int CNT_W               = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  output logic       enUP,
  output logic       enDOWN,
  output logic       enRIGHT,
  output logic       enLEFT,
  output logic [3:0] held
);

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] held_ch;
  logic [NUM_CH-1:0] en_q, en_d;

  assign btn_raw = {btn_up, btn_down, btn_right, btn_left};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (REPEAT_EN),
      .CNT_W              (CNT_W)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .fire   (fire[i]),
      .held   (held_ch[i])
    );
  end

  // Losing requests are dropped, not queued.
  always_comb begin
    en_d = priority_grant(fire);
  end

  always_ff @(posedge clk) begin
    if (reset) en_q <= '0;
    else       en_q <= en_d;
  end

  assign enUP    = en_q[CH_UP];
  assign enDOWN  = en_q[CH_DOWN];
  assign enRIGHT = en_q[CH_RIGHT];
  assign enLEFT  = en_q[CH_LEFT];
  assign held    = held_ch;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed-vector bench for button_pulse_conditioner with a run-length behavioural model.
// Uses short cycle parameters so every debounce/repeat boundary is reached quickly.
module tb_button_pulse_conditioner;

  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
  logic       enUP, enDOWN, enRIGHT, enLEFT;
  logic [3:0] held;

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;
  int pulse_cnt [4];

  // Model state: synchronizer image, debounced level, run lengths and time since hold anchor.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_held = '0, m_en = '0;
  int m_run [4];
  int m_rel [4];
  int m_since [4];

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES (RATE),
    .REPEAT_EN          (1'b1),
    .CNT_W              (26)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_right(btn_right),
    .btn_left (btn_left),
    .enUP     (enUP),
    .enDOWN   (enDOWN),
    .enRIGHT  (enRIGHT),
    .enLEFT   (enLEFT),
    .held     (held)
  );

  // Press accepted after DEB+1 consecutive high samples, release after DEB+1 low samples;
  // pulses at DLY after the hold anchor and then every RATE cycles.
  always @(posedge clk) begin : model
    logic [3:0] req;
    logic [3:0] raw_now;
    raw_now = {btn_up, btn_down, btn_right, btn_left};
    req = '0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_en = '0;
      for (int c = 0; c < 4; c++) begin
        m_run[c] = 0; m_rel[c] = 0; m_since[c] = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (!m_held[c]) begin
          if (m_s2[c]) m_run[c]++;
          else         m_run[c] = 0;
          if (m_run[c] == DEB + 1) begin
            m_held[c] = 1'b1; req[c] = 1'b1;
            m_since[c] = 0; m_run[c] = 0; m_rel[c] = 0;
          end
        end else if (m_s2[c]) begin
          if (m_rel[c] > 0) begin
            m_rel[c] = 0; m_since[c] = 0;
          end else begin
            m_since[c]++;
            if (m_since[c] == DLY || (m_since[c] > DLY && (m_since[c] - DLY) % RATE == 0))
              req[c] = 1'b1;
          end
        end else begin
          m_rel[c]++;
          if (m_rel[c] == DEB + 1) begin
            m_held[c] = 1'b0; m_rel[c] = 0; m_run[c] = 0;
          end
        end
      end
      if (req[3])      m_en = 4'b1000;
      else if (req[2]) m_en = 4'b0100;
      else if (req[1]) m_en = 4'b0010;
      else if (req[0]) m_en = 4'b0001;
      else             m_en = 4'b0000;
      m_s2 = m_s1;
      m_s1 = raw_now;
    end
  end

  // Every-cycle comparison of DUT outputs against the model, plus observed pulse counts.
  always @(negedge clk) begin
    if (check_on) begin
      checks += 2;
      if ({enUP, enDOWN, enRIGHT, enLEFT} !== m_en) begin
        errors++;
        $display("[TB] FAIL model_en @%0t: got %b, expected %b", $time,
                 {enUP, enDOWN, enRIGHT, enLEFT}, m_en);
      end
      if (held !== m_held) begin
        errors++;
        $display("[TB] FAIL model_held @%0t: got %b, expected %b", $time, held, m_held);
      end
      if (enUP)    pulse_cnt[3]++;
      if (enDOWN)  pulse_cnt[2]++;
      if (enRIGHT) pulse_cnt[1]++;
      if (enLEFT)  pulse_cnt[0]++;
    end
  end

  task automatic applyStimulus(input logic u, input logic d, input logic r, input logic l);
    btn_up = u; btn_down = d; btn_right = r; btn_left = l;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (%b), expected %0d (%b)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic clearCounts();
    for (int c = 0; c < 4; c++) pulse_cnt[c] = 0;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0);
    reset = 1'b1;
    tick(3);
    check_on = 1'b1;
    checkOutput("reset_en", {4'b0, enUP, enDOWN, enRIGHT, enLEFT}, 8'd0);
    checkOutput("reset_held", {4'b0, held}, 8'd0);
    reset = 1'b0;
    tick(2);

    $display("[TB] clean press of up");
    clearCounts();
    applyStimulus(1, 0, 0, 0);
    tick(6);
    checkOutput("up_before_pulse", {7'b0, enUP}, 8'd0);
    tick(1);
    checkOutput("up_pulse", {7'b0, enUP}, 8'd1);
    checkOutput("up_held_rise", {4'b0, held}, 8'b0000_1000);
    tick(1);
    checkOutput("up_pulse_width", {7'b0, enUP}, 8'd0);
    applyStimulus(0, 0, 0, 0);
    tick(6);
    checkOutput("up_held_before_fall", {7'b0, held[3]}, 8'd1);
    tick(1);
    checkOutput("up_held_fall", {4'b0, held}, 8'd0);
    tick(4);
    checkOutput("up_pulse_count", 8'(pulse_cnt[3]), 8'd1);

    $display("[TB] down held for auto-repeat");
    clearCounts();
    applyStimulus(0, 1, 0, 0);
    tick(17);
    checkOutput("down_first_repeat", {7'b0, enDOWN}, 8'd1);
    tick(13);
    applyStimulus(0, 0, 0, 0);
    tick(12);
    checkOutput("down_pulse_count", 8'(pulse_cnt[2]), 8'd7);

    $display("[TB] bouncing left press");
    clearCounts();
    applyStimulus(0, 0, 0, 1); tick(1);
    applyStimulus(0, 0, 0, 0); tick(1);
    applyStimulus(0, 0, 0, 1); tick(1);
    applyStimulus(0, 0, 0, 0); tick(1);
    applyStimulus(0, 0, 0, 1);
    tick(6);
    checkOutput("left_before_pulse", {7'b0, enLEFT}, 8'd0);
    tick(1);
    checkOutput("left_pulse", {7'b0, enLEFT}, 8'd1);
    tick(2);
    applyStimulus(0, 0, 0, 0);
    tick(12);
    checkOutput("left_pulse_count", 8'(pulse_cnt[0]), 8'd1);

    $display("[TB] simultaneous up and right");
    clearCounts();
    applyStimulus(1, 0, 1, 0);
    tick(7);
    checkOutput("prio_en", {4'b0, enUP, enDOWN, enRIGHT, enLEFT}, 8'b0000_1000);
    checkOutput("prio_held", {4'b0, held}, 8'b0000_1010);
    tick(1);
    applyStimulus(0, 0, 0, 0);
    tick(12);
    checkOutput("prio_up_count", 8'(pulse_cnt[3]), 8'd1);
    checkOutput("prio_right_count", 8'(pulse_cnt[1]), 8'd0);

    $display("[TB] right release glitch");
    clearCounts();
    applyStimulus(0, 0, 1, 0);
    tick(8);
    applyStimulus(0, 0, 0, 0);
    tick(2);
    applyStimulus(0, 0, 1, 0);
    tick(7);
    checkOutput("glitch_no_old_repeat", {7'b0, enRIGHT}, 8'd0);
    checkOutput("glitch_held", {7'b0, held[1]}, 8'd1);
    tick(6);
    checkOutput("glitch_restarted_repeat", {7'b0, enRIGHT}, 8'd1);
    applyStimulus(0, 0, 0, 0);
    tick(10);
    checkOutput("glitch_pulse_count", 8'(pulse_cnt[1]), 8'd2);

    $display("[TB] reset while down repeats");
    clearCounts();
    applyStimulus(0, 1, 0, 0);
    tick(18);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_en", {4'b0, enUP, enDOWN, enRIGHT, enLEFT}, 8'd0);
    checkOutput("midreset_held", {4'b0, held}, 8'd0);
    reset = 1'b0;
    tick(6);
    checkOutput("post_reset_no_early", {7'b0, enDOWN}, 8'd0);
    tick(1);
    checkOutput("post_reset_pulse", {7'b0, enDOWN}, 8'd1);
    checkOutput("post_reset_held", {4'b0, held}, 8'b0000_0100);
    applyStimulus(0, 0, 0, 0);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
